// File: rtl/axis_pkg.sv
// Shared AXI4-Stream FIFO definitions: default sideband widths and packed-word sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axis_pkg;

    localparam int AXIS_DATA_W_DEF = 32;
    localparam int AXIS_ID_W_DEF   = 1;
    localparam int AXIS_DEST_W_DEF = 1;
    localparam int AXIS_USER_W_DEF = 1;

    // One stored word holds the whole beat: tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
    function automatic int axis_word_w(input int data_w, input int id_w,
                                       input int dest_w, input int user_w);
        return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller guarantees it never overwrites unread entries.
module axis_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    // Storage is deliberately left unreset; the pointers define what is valid.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Capture the incoming word on a write strobe.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read gives first-word-fall-through at the top level.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO with fill level; AXIS_FIFO_PACKET_MODE_EN selects store-and-forward.
// Latency: beat pushed at edge N is valid on m_axis the cycle after N (FWFT), 1 beat/cycle sustained.
// Backpressure: registered s_axis_tready = !full, no ready-through-pop; m_axis payload held while stalled.
module axis_sync_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W_DEF,
    parameter int ID_W   = AXIS_ID_W_DEF,
    parameter int DEST_W = AXIS_DEST_W_DEF,
    parameter int USER_W = AXIS_USER_W_DEF,
    parameter int DEPTH  = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_W-1:0]         s_axis_tdata,
    input  logic [DATA_W/8-1:0]       s_axis_tstrb,
    input  logic [DATA_W/8-1:0]       s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic [ID_W-1:0]           s_axis_tid,
    input  logic [DEST_W-1:0]         s_axis_tdest,
    input  logic [USER_W-1:0]         s_axis_tuser,

    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [DATA_W/8-1:0]       m_axis_tstrb,
    output logic [DATA_W/8-1:0]       m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [ID_W-1:0]           m_axis_tid,
    output logic [DEST_W-1:0]         m_axis_tdest,
    output logic [USER_W-1:0]         m_axis_tuser,

    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
`ifdef AXIS_FIFO_PACKET_MODE_EN
    ,
    output logic [$clog2(DEPTH):0]    pkt_count
`endif
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;
    localparam int WORD_W = axis_word_w(DATA_W, ID_W, DEST_W, USER_W);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic              rdy_q,    rdy_d;

    logic              push;
    logic              pop;
    logic              out_vld;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] out_word;

    assign push = s_axis_tvalid && rdy_q;
    assign pop  = out_vld && m_axis_tready;

    // The whole beat travels as one word so sideband can never slip relative to data.
    assign wr_word = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                      s_axis_tid, s_axis_tdest, s_axis_tuser};

    axis_fifo_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (aclk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_word),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_word)
    );

    // Next pointers and level; simultaneous push and pop cancel on the level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Ready is computed from the next level so the register tracks !full exactly,
        // with no combinational path from m_axis_tready back to s_axis_tready.
        rdy_d = (level_d != LW'(DEPTH));
    end

    // Pointer, level and ready state; ready stays low throughout reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdy_q    <= rdy_d;
        end
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [LW-1:0] pkt_q, pkt_d;
    logic          push_last;
    logic          pop_last;

    // The tlast bit of the word under the read pointer sits just above the sideband fields.
    assign push_last = push && s_axis_tlast;
    assign pop_last  = pop && rd_word[ID_W + DEST_W + USER_W];

    // Count of complete packets held; a stored and a departing tlast in one cycle cancel.
    always_comb begin
        pkt_d = pkt_q;
        if (push_last && !pop_last) begin
            pkt_d = pkt_q + LW'(1);
        end else if (!push_last && pop_last) begin
            pkt_d = pkt_q - LW'(1);
        end
    end

    // Packet counter register, cleared so a reset discards any partial packet.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    // Release only whole packets, except when a packet larger than the FIFO has
    // filled it: then let it cut through so the stream cannot deadlock.
    assign out_vld   = (level_q != '0) && ((pkt_q != '0) || full);
    assign pkt_count = pkt_q;
`else
    // Cut-through: anything stored is presented immediately.
    assign out_vld = (level_q != '0);
`endif

    // Payload reads as zero whenever nothing is being presented.
    assign out_word = out_vld ? rd_word : '0;

    assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = out_word;

    assign m_axis_tvalid = out_vld;
    assign s_axis_tready = rdy_q;
    assign level         = level_q;
    assign full          = (level_q == LW'(DEPTH));
    assign empty         = (level_q == '0);

    // Tie off the unused parameter-derived width to keep the byte-lane sizing explicit.
    logic [KEEP_W-1:0] keep_w_unused;
    assign keep_w_unused = s_axis_tkeep & s_axis_tstrb;
    logic unused_ok;
    assign unused_ok = &{1'b0, keep_w_unused};

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed-vector and scoreboard bench for axis_sync_fifo (DEPTH=16, 32-bit data, wide sideband).
// Latency: checks 1-cycle FWFT and 1 beat/cycle streaming.
// Backpressure: exercises full, stalls and (with AXIS_FIFO_PACKET_MODE_EN) store-and-forward.
module tb_axis_sync_fifo;

    localparam int DATA_W = 32;
    localparam int ID_W   = 2;
    localparam int DEST_W = 3;
    localparam int USER_W = 4;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  id;
        logic [2:0]  dest;
        logic [3:0]  user;
    } beat_t;

    typedef struct {
        bit          sv;
        logic [31:0] sd;
        bit          sl;
        bit          mr;
        bit          mv;
        logic [31:0] md;
        bit          ml;
        int          lvl;
        bit          srdy;
    } vec_t;

    logic              aclk;
    logic              aresetn;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [31:0]       s_axis_tdata;
    logic [3:0]        s_axis_tstrb;
    logic [3:0]        s_axis_tkeep;
    logic              s_axis_tlast;
    logic [1:0]        s_axis_tid;
    logic [2:0]        s_axis_tdest;
    logic [3:0]        s_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [31:0]       m_axis_tdata;
    logic [3:0]        m_axis_tstrb;
    logic [3:0]        m_axis_tkeep;
    logic              m_axis_tlast;
    logic [1:0]        m_axis_tid;
    logic [2:0]        m_axis_tdest;
    logic [3:0]        m_axis_tuser;
    logic [4:0]        level;
    logic              full;
    logic              empty;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [4:0]        pkt_count;
`endif

    axis_sync_fifo #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .DEST_W (DEST_W),
        .USER_W (USER_W),
        .DEPTH  (DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .level         (level),
        .full          (full),
        .empty         (empty)
`ifdef AXIS_FIFO_PACKET_MODE_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    int    tests = 0;
    int    fails = 0;
    beat_t out_beat;
    vec_t  vt [12];

    assign out_beat = {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
                       m_axis_tid, m_axis_tdest, m_axis_tuser};

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sideband derived from data so every field is distinguishable per beat.
    function automatic beat_t mk(input logic [31:0] d, input bit l);
        beat_t b;
        b.data = d;
        b.strb = d[7:4];
        b.keep = 4'hF;
        b.last = l;
        b.id   = {1'b0, d[0]};
        b.dest = d[10:8];
        b.user = {3'b000, d[0]};
        return b;
    endfunction

    function automatic beat_t rand_beat();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[$bits(beat_t)-1:0];
    endfunction

    task automatic drive(input beat_t b, input bit v);
        s_axis_tvalid = v;
        s_axis_tdata  = b.data;
        s_axis_tstrb  = b.strb;
        s_axis_tkeep  = b.keep;
        s_axis_tlast  = b.last;
        s_axis_tid    = b.id;
        s_axis_tdest  = b.dest;
        s_axis_tuser  = b.user;
    endtask

    // Random traffic against a queue scoreboard; called just after a rising edge.
    task automatic run(input int n, input int vpct, input int rpct, input bit last_on_end,
                       input int budget, output int cycles, output int maxlvl);
        beat_t q[$];
        beat_t cur;
        bit    have;
        int    sent;
        int    rcvd;
        have = 0; sent = 0; rcvd = 0; cycles = 0; maxlvl = 0;
        cur = '0;
        while (rcvd < n && cycles < budget) begin
            if (!have && sent < n && $urandom_range(99) < vpct) begin
                cur = rand_beat();
                if (last_on_end) cur.last = (sent == n - 1);
                have = 1;
            end
            drive(cur, have);
            m_axis_tready = ($urandom_range(99) < rpct);
            @(negedge aclk);
            check("run_level", level, q.size());
            if (int'(level) > maxlvl) maxlvl = int'(level);
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) check("run_underrun", 1, 0);
                else check("run_beat", out_beat, q.pop_front());
                rcvd++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                q.push_back(cur);
                have = 0;
                sent++;
            end
            @(posedge aclk); #1;
            cycles++;
        end
        drive('0, 0);
        m_axis_tready = 1'b0;
        check("run_delivered", rcvd, n);
    endtask

    initial begin
        beat_t fq[$];
        beat_t cur;
        int    idx;
        int    rcvd;
        int    cyc;
        int    mx;

        // Directed cycle-by-cycle vectors; every beat carries tlast so they hold in both modes.
        vt[0]  = '{1, 32'hDEADBEEF, 1, 0,  0, 32'h0,        0, 0, 1};
        vt[1]  = '{0, 32'h0,        0, 0,  1, 32'hDEADBEEF, 1, 1, 1};
        vt[2]  = '{0, 32'h0,        0, 1,  1, 32'hDEADBEEF, 1, 1, 1};
        vt[3]  = '{1, 32'h11111111, 1, 1,  0, 32'h0,        0, 0, 1};
        vt[4]  = '{1, 32'h22222222, 1, 1,  1, 32'h11111111, 1, 1, 1};
        vt[5]  = '{0, 32'h0,        0, 1,  1, 32'h22222222, 1, 1, 1};
        vt[6]  = '{1, 32'h33333333, 1, 0,  0, 32'h0,        0, 0, 1};
        vt[7]  = '{1, 32'h44444444, 1, 0,  1, 32'h33333333, 1, 1, 1};
        vt[8]  = '{0, 32'h0,        0, 0,  1, 32'h33333333, 1, 2, 1};
        vt[9]  = '{0, 32'h0,        0, 1,  1, 32'h33333333, 1, 2, 1};
        vt[10] = '{0, 32'h0,        0, 1,  1, 32'h44444444, 1, 1, 1};
        vt[11] = '{0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 1};

        // Reset for 5 cycles.
        aresetn = 1'b0;
        drive('0, 0);
        m_axis_tready = 1'b0;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_tdata", m_axis_tdata, 0);
        aresetn = 1'b1;
        #1;
        check("rel_tready_before_edge", s_axis_tready, 0);
        @(posedge aclk); #1;
        check("rel_tready_after_edge", s_axis_tready, 1);
        check("rel_empty", empty, 1);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            drive(mk(vt[i].sd, vt[i].sl), vt[i].sv);
            m_axis_tready = vt[i].mr;
            @(negedge aclk);
            check($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vt[i].mv);
            check($sformatf("vec%0d_level", i), level, vt[i].lvl);
            check($sformatf("vec%0d_empty", i), empty, vt[i].lvl == 0);
            check($sformatf("vec%0d_tready", i), s_axis_tready, vt[i].srdy);
            if (vt[i].mv) check($sformatf("vec%0d_beat", i), out_beat, mk(vt[i].md, vt[i].ml));
            else          check($sformatf("vec%0d_zero", i), out_beat, 0);
            @(posedge aclk); #1;
        end
        drive('0, 0);
        m_axis_tready = 1'b0;

        // Reset mid-packet discards the partial packet.
        for (int i = 0; i < 3; i++) begin
            drive(mk(32'h500 + i, 0), 1);
            @(posedge aclk); #1;
        end
        drive('0, 0);
        check("midrst_level_before", level, 3);
        aresetn = 1'b0;
        #1;
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_tready", s_axis_tready, 0);
        check("midrst_tdata", m_axis_tdata, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("midrst_tready_back", s_axis_tready, 1);

        // Fill with the sink stalled: only 16 of 20 beats get in.
        idx = 0;
        m_axis_tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cur = mk(idx, idx == 19);
            drive(cur, idx < 20);
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) begin
                fq.push_back(cur);
                idx++;
            end
            @(posedge aclk); #1;
        end
        check("fill_accepted", idx, 16);
        check("fill_full", full, 1);
        check("fill_tready", s_axis_tready, 0);
        check("fill_level", level, 16);
        check("fill_empty", empty, 0);

        // Drain; the first pop while full must not open ready in that same cycle.
        m_axis_tready = 1'b1;
        rcvd = 0;
        for (int c = 0; c < 80 && rcvd < 20; c++) begin
            cur = mk(idx, idx == 19);
            drive(cur, idx < 20);
            @(negedge aclk);
            if (c == 0) check("full_pop_no_ready", s_axis_tready, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (fq.size() == 0) check("fill_underrun", 1, 0);
                else check("fill_beat", out_beat, fq.pop_front());
                rcvd++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                fq.push_back(cur);
                idx++;
            end
            @(posedge aclk); #1;
        end
        drive('0, 0);
        m_axis_tready = 1'b0;
        check("fill_received", rcvd, 20);
        check("fill_sent", idx, 20);
        check("fill_drained_empty", empty, 1);

`ifndef AXIS_FIFO_PACKET_MODE_EN
        // Streaming: 1000 beats, both sides always ready.
        run(1000, 100, 100, 0, 3000, cyc, mx);
        check("stream_cycles", cyc, 1001);
        check("stream_maxlevel", mx, 1);
`endif

        // Random stalls on both sides with random tlast.
        run(5000, 70, 70, 0, 40000, cyc, mx);
        check("stall_maxlevel_le_depth", mx <= DEPTH, 1);
        check("stall_end_empty", empty, 1);

`ifdef AXIS_FIFO_PACKET_MODE_EN
        // Store-and-forward: nothing appears until the tlast beat is stored.
        m_axis_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fq.push_back(mk(32'h700 + k, k == 3));
            drive(mk(32'h700 + k, k == 3), 1);
            @(negedge aclk);
            check("pkt_hold_tvalid", m_axis_tvalid, 0);
            @(posedge aclk); #1;
            drive('0, 0);
            if (k < 3) begin
                repeat (3) begin
                    @(negedge aclk);
                    check("pkt_gap_tvalid", m_axis_tvalid, 0);
                    check("pkt_gap_count", pkt_count, 0);
                    @(posedge aclk); #1;
                end
            end
        end
        @(negedge aclk);
        check("pkt_release_tvalid", m_axis_tvalid, 1);
        check("pkt_release_count", pkt_count, 1);
        check("pkt_release_level", level, 4);
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            check("pkt_out_tvalid", m_axis_tvalid, 1);
            check("pkt_out_beat", out_beat, fq.pop_front());
            @(posedge aclk); #1;
        end
        m_axis_tready = 1'b0;
        check("pkt_drained_count", pkt_count, 0);
        check("pkt_drained_empty", empty, 1);

        // Oversize packet: released once the FIFO fills.
        run(20, 100, 100, 1, 400, cyc, mx);
        check("oversize_reached_full", mx, DEPTH);
        check("oversize_count", pkt_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
